// File: rtl/spectrum_classifier.sv
// Two-pass spectrum classifier: carrier (global max) search, then local-peak count and sideband spacing.
// Optional SPEC_CLS_SYMM_EN: AM is kept only when the nearest sidebands on both sides are symmetric.
module spectrum_classifier #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DC_SKIP      = 2,
  parameter int unsigned THRESH_SHIFT = 3,
  parameter int unsigned FM_MIN_PEAKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        mod_type,
  output logic [ADDR_W-1:0] carrier_bin,
  output logic [DATA_W-1:0] max_mag,
  output logic [ADDR_W-1:0] peak_cnt,
  output logic [ADDR_W-1:0] spacing
);

  localparam int unsigned       HALF      = (2 ** ADDR_W) / 2;
  localparam int unsigned       SCAN_LEN  = HALF - DC_SKIP;
  localparam logic [ADDR_W-1:0] FIRST_BIN = ADDR_W'(DC_SKIP);
  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(HALF - 1);
  localparam logic [ADDR_W-1:0] LEN       = ADDR_W'(SCAN_LEN);
  localparam logic [ADDR_W-1:0] LEN_M1    = ADDR_W'(SCAN_LEN - 1);
  localparam logic [ADDR_W-1:0] FM_MIN    = ADDR_W'(FM_MIN_PEAKS);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [2:0]        MOD_NONE  = 3'b000;
  localparam logic [2:0]        MOD_CW    = 3'b001;
  localparam logic [2:0]        MOD_AM    = 3'b010;
  localparam logic [2:0]        MOD_FM    = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN_MAX, S_SCAN_PEAK, S_CLASSIFY, S_DONE
  } state_t;

  function automatic logic is_peak(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] c,
                                   input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] thr,
                                   input logic nz);
    return nz && (c > p) && (c >= n) && (c >= thr);
  endfunction

  function automatic logic [ADDR_W-1:0] absdiff(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   wmax_q, wmax_d;
  logic [ADDR_W-1:0]   wbin_q, wbin_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [DATA_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   pcnt_q, pcnt_d;
`ifdef SPEC_CLS_SYMM_EN
  logic [ADDR_W-1:0]   dl_q, dl_d;
  logic [ADDR_W-1:0]   dr_q, dr_d;
`else
  logic [ADDR_W-1:0]   dmin_q, dmin_d;
`endif
  logic [2:0]          mod_q, mod_d;
  logic [ADDR_W-1:0]   cb_q, cb_d;
  logic [DATA_W-1:0]   mag_q, mag_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;

  logic [DATA_W-1:0]   thr;
  logic                nz;
  logic [ADDR_W-1:0]   samp_bin;
  logic                hit;
  logic [ADDR_W-1:0]   hit_bin;
  logic [ADDR_W-1:0]   hit_dist;

  // rd_data in a cycle with counter j belongs to the bin addressed one cycle earlier
  assign thr      = wmax_q >> THRESH_SHIFT;
  assign nz       = (wmax_q != '0);
  assign samp_bin = FIRST_BIN + cnt_q - ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wmax_d    = wmax_q;
    wbin_d    = wbin_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    pcnt_d    = pcnt_q;
`ifdef SPEC_CLS_SYMM_EN
    dl_d      = dl_q;
    dr_d      = dr_q;
`else
    dmin_d    = dmin_q;
`endif
    mod_d     = mod_q;
    cb_d      = cb_q;
    mag_d     = mag_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    hit       = 1'b0;
    hit_bin   = '0;
    hit_dist  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SCAN_MAX;
          cnt_d     = '0;
          rd_addr_d = FIRST_BIN;
          busy_d    = 1'b1;
          wmax_d    = '0;
          wbin_d    = FIRST_BIN;
        end
      end

      S_SCAN_MAX: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q < LEN_M1) rd_addr_d = rd_addr_q + ONE;
        // strict compare keeps the lowest index on ties
        if (cnt_q != '0 && rd_data > wmax_q) begin
          wmax_d = rd_data;
          wbin_d = samp_bin;
        end
        if (cnt_q == LEN) begin
          state_d   = S_SCAN_PEAK;
          cnt_d     = '0;
          rd_addr_d = FIRST_BIN;
          prev_d    = '0;
          cur_d     = '0;
          pcnt_d    = '0;
`ifdef SPEC_CLS_SYMM_EN
          dl_d      = '0;
          dr_d      = '0;
`else
          dmin_d    = '0;
`endif
        end
      end

      S_SCAN_PEAK: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q < LEN_M1) rd_addr_d = rd_addr_q + ONE;
        if (cnt_q != '0) begin
          prev_d = cur_q;
          cur_d  = rd_data;
        end
        // the last sample also closes the top bin, whose upper neighbour reads as 0
        if (cnt_q >= ADDR_W'(2)) begin
          if (is_peak(prev_q, cur_q, rd_data, thr, nz)) begin
            hit     = 1'b1;
            hit_bin = samp_bin - ONE;
          end else if (cnt_q == LEN && is_peak(cur_q, rd_data, {DATA_W{1'b0}}, thr, nz)) begin
            hit     = 1'b1;
            hit_bin = LAST_BIN;
          end
        end
        if (hit) begin
          if (pcnt_q != '1) pcnt_d = pcnt_q + ONE;
          if (hit_bin != wbin_q) begin
            hit_dist = absdiff(hit_bin, wbin_q);
`ifdef SPEC_CLS_SYMM_EN
            if (hit_bin < wbin_q) begin
              if (dl_q == '0 || hit_dist < dl_q) dl_d = hit_dist;
            end else if (dr_q == '0 || hit_dist < dr_q) begin
              dr_d = hit_dist;
            end
`else
            if (dmin_q == '0 || hit_dist < dmin_q) dmin_d = hit_dist;
`endif
          end
        end
        if (cnt_q == LEN) state_d = S_CLASSIFY;
      end

      S_CLASSIFY: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        if (pcnt_q == '0)         mod_d = MOD_NONE;
        else if (pcnt_q == ONE)   mod_d = MOD_CW;
        else if (pcnt_q < FM_MIN) mod_d = MOD_AM;
        else                      mod_d = MOD_FM;
`ifdef SPEC_CLS_SYMM_EN
        if (mod_d == MOD_AM &&
            !(dl_q != '0 && dr_q != '0 && absdiff(dl_q, dr_q) <= ONE)) mod_d = MOD_FM;
        sp_d = (dl_q < dr_q) ? dl_q : dr_q;
`else
        sp_d = dmin_q;
`endif
        cb_d  = wbin_q;
        mag_d = wmax_q;
        pc_d  = pcnt_q;
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wmax_q    <= '0;
      wbin_q    <= '0;
      prev_q    <= '0;
      cur_q     <= '0;
      pcnt_q    <= '0;
`ifdef SPEC_CLS_SYMM_EN
      dl_q      <= '0;
      dr_q      <= '0;
`else
      dmin_q    <= '0;
`endif
      mod_q     <= '0;
      cb_q      <= '0;
      mag_q     <= '0;
      pc_q      <= '0;
      sp_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wmax_q    <= wmax_d;
      wbin_q    <= wbin_d;
      prev_q    <= prev_d;
      cur_q     <= cur_d;
      pcnt_q    <= pcnt_d;
`ifdef SPEC_CLS_SYMM_EN
      dl_q      <= dl_d;
      dr_q      <= dr_d;
`else
      dmin_q    <= dmin_d;
`endif
      mod_q     <= mod_d;
      cb_q      <= cb_d;
      mag_q     <= mag_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign mod_type    = mod_q;
  assign carrier_bin = cb_q;
  assign max_mag     = mag_q;
  assign peak_cnt    = pc_q;
  assign spacing     = sp_q;

endmodule
